mem_arbiter: RTL
================

# mem_arbiter

Shares the single cache-line AXI master port (128-bit line, 27-bit address, `rd_en`/`rd_fin`, `wr_en`/`wr_fin` pulse interface) between two requesters: port 0 (instruction cache, read-only) and port 1 (data cache, read/write).
- Serialises reads, since the master handles one read at a time.
- Forwards write-backs into the master's write FIFO.
- Tracks outstanding writes so no read can overtake a posted write. This preserves read-after-write ordering.

## Interface
Parameters:
- ADDR_W, 27, line address width
- DATA_W, 128, line data width
- WR_MAX, 8, maximum outstanding (issued, not finished) writes; 1..15

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset, synchronous, active-low
- p0_rd_req  in  1  port-0 read request, level, held until ack
- p0_rd_addr  in  ADDR_W  port-0 read address, stable while req
- p0_rd_ack  out  1  one-cycle pulse, p0_rd_data valid
- p0_rd_data  out  DATA_W  port-0 read line
- p1_rd_req / p1_rd_addr / p1_rd_ack / p1_rd_data  same as port 0, for port 1
- p1_wr_req  in  1  port-1 write request, level, held until ack
- p1_wr_addr  in  ADDR_W  write address
- p1_wr_data  in  DATA_W  write line
- p1_wr_ack  out  1  one-cycle pulse, write accepted (posted)
- m_rd_en  out  1  one-cycle read start to master
- m_rd_addr  out  ADDR_W  read address to master
- m_rd_fin  in  1  master read done pulse, m_rd_data valid same cycle
- m_rd_data  in  DATA_W  master read line
- m_wr_en  out  1  one-cycle write push to master
- m_wr_addr  out  ADDR_W  write address to master
- m_wr_data  out  DATA_W  write line to master
- m_wr_fin  in  1  master write completion pulse
- pend_wr  out  4  outstanding write count

## Operation
- States: IDLE, WR, RD_REQ, RD_WAIT, RESP.
- All outputs are registered. Reset values are 0 for every output, pend_wr, and the RR pointer; state is IDLE.
- IDLE decisions, in priority order:
  - If p1_wr_req && pend_wr < WR_MAX: go to WR, latch wr addr/data.
  - Else if pend_wr == 0 and any rd_req: pick a winner (see Configuration), latch its address and id, go to RD_REQ.
  - Else stay in IDLE. Reads are blocked while any write is outstanding.
- WR: m_wr_en=1 and p1_wr_ack=1 for this cycle only; next state IDLE.
- RD_REQ: m_rd_en=1 with m_rd_addr for one cycle; next state RD_WAIT.
- RD_WAIT: hold until m_rd_fin, latching m_rd_data; next state RESP.
- RESP: winner's rd_ack=1 and rd_data=latched line for one cycle; the other port's ack stays 0; next state IDLE.
- pend_wr counter:
  - +1 on m_wr_en.
  - -1 on m_wr_fin.
  - Unchanged when both occur in the same cycle.
  - m_wr_fin at 0 leaves it at 0 (no underflow).
- m_rd_fin outside RD_WAIT is ignored.
- p*_rd_data holds its last value between acks.

## Timing
- Requesters drive req from a register and drop it the cycle after they sample ack. The IDLE cycle after WR/RESP therefore sees the acked request already low.
- Read, req high at T0 in IDLE with pend_wr=0:
  - T1: m_rd_en.
  - T2 onward: RD_WAIT.
  - m_rd_fin at Tn gives rd_ack at Tn+1.
  - Overhead is 2 cycles plus master latency.
- Write, req at T0 in IDLE: m_wr_en and p1_wr_ack at T1; pend_wr increments at T2.
- A write request wins over a read request in the same IDLE cycle.
- Reset mid-transaction: returns to IDLE, drops all pulses, clears pend_wr. Any in-flight master transaction is abandoned, since the master resets on the same ARESETN.

## Configuration
- MEM_ARB_RR_EN defined: read arbitration is round-robin. A 1-bit pointer points at the port that did not win the last read. When both ports request, the pointer's port wins, then the pointer flips.
- MEM_ARB_RR_EN undefined: fixed priority, port 1 (data cache) always wins. The pointer logic is not built.

## Test plan
- Reset: hold ARESETN=0 for 3 cycles with all reqs high → all outputs 0, pend_wr=0, no m_rd_en/m_wr_en.
- Single read: p0_rd_req, addr 0x0000100, master returns 0xA5…A5 with m_rd_fin 5 cycles after m_rd_en → m_rd_addr=0x0000100; p0_rd_ack one cycle after m_rd_fin with data 0xA5…A5; p1_rd_ack stays 0.
- RAW ordering: p1 write to 0x0000200, then p0_rd_req to 0x0000200 → m_rd_en is held off until m_wr_fin and pend_wr 1→0; the read issues in the following IDLE cycle.
- Contention: both rd_req held for 4 grants.
  - With MEM_ARB_RR_EN: winners alternate 0,1,0,1.
  - Without: 1,1,1,1.
- Write saturation: WR_MAX=2, three back-to-back p1 writes, no m_wr_fin → two acks, pend_wr=2, third ack only after the first m_wr_fin. Simultaneous m_wr_en/m_wr_fin keeps pend_wr=2.
- Reset mid-read: ARESETN low during RD_WAIT → no rd_ack; after release, a new p1 read completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one cache-line memory master between the I-cache (port 0, reads) and D-cache (port 1, reads/writes).
// Define MEM_ARB_RR_EN for round-robin read arbitration; otherwise port 1 always wins a read tie.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 27,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned WR_MAX = 8
) (
  input  logic              ACLK,
  input  logic              ARESETN,

  input  logic              p0_rd_req,
  input  logic [ADDR_W-1:0] p0_rd_addr,
  output logic              p0_rd_ack,
  output logic [DATA_W-1:0] p0_rd_data,

  input  logic              p1_rd_req,
  input  logic [ADDR_W-1:0] p1_rd_addr,
  output logic              p1_rd_ack,
  output logic [DATA_W-1:0] p1_rd_data,

  input  logic              p1_wr_req,
  input  logic [ADDR_W-1:0] p1_wr_addr,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p1_wr_ack,

  output logic              m_rd_en,
  output logic [ADDR_W-1:0] m_rd_addr,
  input  logic              m_rd_fin,
  input  logic [DATA_W-1:0] m_rd_data,

  output logic              m_wr_en,
  output logic [ADDR_W-1:0] m_wr_addr,
  output logic [DATA_W-1:0] m_wr_data,
  input  logic              m_wr_fin,

  output logic [3:0]        pend_wr
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_REQ,
    RD_WAIT,
    RESP
  } state_t;

  localparam logic [3:0] WR_LIMIT = 4'(WR_MAX);

  state_t state, state_nx;
  logic   take_wr;
  logic   take_rd;
  logic   rd_win;
  logic   rd_id;
  logic   rd_done;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr;

  // rr_ptr names the port that lost (or did not take part in) the last read grant.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rr_ptr <= 1'b0;
    end else if (take_rd) begin
      rr_ptr <= ~rd_win;
    end
  end

  always_comb begin
    rd_win = p1_rd_req;
    if (p0_rd_req && p1_rd_req) begin
      rd_win = rr_ptr;
    end
  end
`else
  always_comb begin
    rd_win = p1_rd_req;
  end
`endif

  always_comb begin
    state_nx = state;
    take_wr  = 1'b0;
    take_rd  = 1'b0;
    rd_done  = 1'b0;
    case (state)
      IDLE: begin
        if (p1_wr_req && (pend_wr < WR_LIMIT)) begin
          state_nx = WR;
          take_wr  = 1'b1;
        end else if ((pend_wr == '0) && (p0_rd_req || p1_rd_req)) begin
          state_nx = RD_REQ;
          take_rd  = 1'b1;
        end
      end
      WR:      state_nx = IDLE;
      RD_REQ:  state_nx = RD_WAIT;
      RD_WAIT: begin
        if (m_rd_fin) begin
          state_nx = RESP;
          rd_done  = 1'b1;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Every output is a register loaded on the transition into the state that owns it,
  // so pulses line up with the WR / RD_REQ / RESP cycles.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      p0_rd_ack  <= 1'b0;
      p1_rd_ack  <= 1'b0;
      p0_rd_data <= '0;
      p1_rd_data <= '0;
      p1_wr_ack  <= 1'b0;
      m_rd_en    <= 1'b0;
      m_rd_addr  <= '0;
      m_wr_en    <= 1'b0;
      m_wr_addr  <= '0;
      m_wr_data  <= '0;
      rd_id      <= 1'b0;
    end else begin
      m_wr_en   <= take_wr;
      p1_wr_ack <= take_wr;
      m_rd_en   <= take_rd;
      p0_rd_ack <= rd_done && !rd_id;
      p1_rd_ack <= rd_done && rd_id;

      if (take_wr) begin
        m_wr_addr <= p1_wr_addr;
        m_wr_data <= p1_wr_data;
      end

      if (take_rd) begin
        rd_id     <= rd_win;
        m_rd_addr <= rd_win ? p1_rd_addr : p0_rd_addr;
      end

      if (rd_done) begin
        if (rd_id) begin
          p1_rd_data <= m_rd_data;
        end else begin
          p0_rd_data <= m_rd_data;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      pend_wr <= '0;
    end else begin
      case ({m_wr_en, m_wr_fin})
        2'b10:   pend_wr <= pend_wr + 4'd1;
        2'b01:   if (pend_wr != '0) pend_wr <= pend_wr - 4'd1;
        default: pend_wr <= pend_wr;
      endcase
    end
  end

endmodule
